// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and default width for the ALU/MDU slice.
package alu_pkg;
    localparam int DEF_WIDTH = 32;

    localparam logic [4:0] OP_ADDU    = 5'h00;
    localparam logic [4:0] OP_SUBU    = 5'h01;
    localparam logic [4:0] OP_ADD     = 5'h02;
    localparam logic [4:0] OP_SUB     = 5'h03;
    localparam logic [4:0] OP_AND     = 5'h04;
    localparam logic [4:0] OP_OR      = 5'h05;
    localparam logic [4:0] OP_XOR     = 5'h06;
    localparam logic [4:0] OP_NOR     = 5'h07;
    localparam logic [4:0] OP_LUI     = 5'h08;
    localparam logic [4:0] OP_LUI_ALT = 5'h09;
    localparam logic [4:0] OP_SLTU    = 5'h0A;
    localparam logic [4:0] OP_SLT     = 5'h0B;
    localparam logic [4:0] OP_SRA     = 5'h0C;
    localparam logic [4:0] OP_SRL     = 5'h0D;
    localparam logic [4:0] OP_SLL     = 5'h0E;
    localparam logic [4:0] OP_SLL_ALT = 5'h0F;
    localparam logic [4:0] OP_MULT    = 5'h10;
    localparam logic [4:0] OP_MULTU   = 5'h11;
    localparam logic [4:0] OP_DIV     = 5'h12;
    localparam logic [4:0] OP_DIVU    = 5'h13;
    localparam logic [4:0] OP_MTHI    = 5'h14;
    localparam logic [4:0] OP_MTLO    = 5'h15;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:2] == 3'b100;
    endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative multiply (shift-add) / divide (restoring) on operand magnitudes,
// sign fix-up applied combinationally to the final step so results land on the last edge.
module alu_muldiv_iter import alu_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       mode,   // [1]=divide, [0]=unsigned
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             fin,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc, q, m;
    logic               is_div, neg_q, neg_r, b_zero;
    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum, rsh;
    logic [WIDTH-1:0]   diff, nh, nl;
    logic               ge;
    logic [2*WIDTH-1:0] prod;

    assign sgn   = ~mode[0];
    assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;
    assign fin   = (cnt == CW'(WIDTH-1));

    // acc is the product high half / partial remainder; q the multiplier / dividend-quotient
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
        end else if (load) begin
            cnt    <= '0;
            acc    <= '0;
            q      <= mode[1] ? mag_a : mag_b;
            m      <= mode[1] ? mag_b : mag_a;
            is_div <= mode[1];
            neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn && a[WIDTH-1];
            b_zero <= (b == '0);
        end else if (step) begin
            cnt <= cnt + 1'b1;
            acc <= nh;
            q   <= nl;
        end
    end

    always_comb begin
        sum  = {1'b0, acc} + {1'b0, (q[0] ? m : {WIDTH{1'b0}})};
        rsh  = {acc, q[WIDTH-1]};
        ge   = (rsh >= {1'b0, m});
        diff = rsh[WIDTH-1:0] - m;
        prod = '0;
        if (is_div) begin
            nh = ge ? diff : rsh[WIDTH-1:0];
            nl = {q[WIDTH-2:0], ge};
            // divide by zero leaves quotient all-ones and remainder = |a|; skip quotient negation
            lo_res = (neg_q && !b_zero) ? -nl : nl;
            hi_res = neg_r ? -nh : nh;
        end else begin
            nh   = sum[WIDTH:1];
            nl   = {sum[0], q[WIDTH-1:1]};
            prod = neg_q ? -{nh, nl} : {nh, nl};
            {hi_res, lo_res} = prod;
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// Single-cycle ALU with an iterative multiply/divide unit and HI/LO registers.
module alu_mdu import alu_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    state_t           state, nxt;
    logic             accept, md_op, md_fin;
    logic [WIDTH-1:0] md_hi, md_lo, sr;
    logic [SW-1:0]    sh;
    logic             sc, sv, known;

    assign md_op  = is_muldiv(op);
    assign accept = start && (state != ST_RUN);
    assign sh     = a[SW-1:0];
    assign known  = (op <= OP_MTLO);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept && md_op),
        .step   (state == ST_RUN),
        .mode   (op[1:0]),
        .a      (a),
        .b      (b),
        .fin    (md_fin),
        .hi_res (md_hi),
        .lo_res (md_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE, ST_DONE: nxt = start ? (md_op ? ST_RUN : ST_DONE) : ST_IDLE;
            ST_RUN:           nxt = md_fin ? ST_DONE : ST_RUN;
            default:          nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // shifts carry the last bit shifted out in an extra bit beside the result
    always_comb begin
        sr = '0;
        sc = 1'b0;
        sv = 1'b0;
        case (op)
            OP_ADDU: {sc, sr} = {1'b0, a} + {1'b0, b};
            OP_SUBU: begin sr = a - b; sc = (a < b); end
            OP_ADD:  begin sr = a + b; sv = (a[M] == b[M]) && (sr[M] != a[M]); end
            OP_SUB:  begin sr = a - b; sv = (a[M] != b[M]) && (sr[M] != a[M]); end
            OP_AND:  sr = a & b;
            OP_OR:   sr = a | b;
            OP_XOR:  sr = a ^ b;
            OP_NOR:  sr = ~(a | b);
            OP_LUI, OP_LUI_ALT: sr = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLTU: begin sr = {{(WIDTH-1){1'b0}}, a < b}; sc = (a < b); end
            OP_SLT:  sr = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SRA:  {sr, sc} = $signed({b, 1'b0}) >>> sh;
            OP_SRL:  {sr, sc} = {b, 1'b0} >> sh;
            OP_SLL, OP_SLL_ALT: {sc, sr} = {1'b0, b} << sh;
            OP_MTHI, OP_MTLO: sr = a;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r        <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (accept && !md_op) begin
            r        <= sr;
            zero     <= known && (sr == '0);
            carry    <= sc;
            negative <= sr[M];
            overflow <= sv;
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
        end else if (state == ST_RUN && md_fin) begin
            r        <= md_lo;
            hi       <= md_hi;
            lo       <= md_lo;
            zero     <= (md_lo == '0);
            negative <= md_lo[M];
            carry    <= 1'b0;
            overflow <= 1'b0;
        end
    end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are powers of two, 8 to 64.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  operation request, sampled only when busy=0.
REQ-005 SHALL have port op  input  5  operation code, per REQ-012.
REQ-006 SHALL have ports a, b  input  WIDTH  operands; a also supplies the shift amount.
REQ-007 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port r  output  WIDTH  registered result.
REQ-010 SHALL have ports zero, carry, negative, overflow  output  1 each  registered flags, never high-impedance.
REQ-011 SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-012 op codes: 0x00 addu, 0x01 subu, 0x02 add, 0x03 sub, 0x04 and, 0x05 or, 0x06 xor, 0x07 nor, 0x08/0x09 lui, 0x0A sltu, 0x0B slt, 0x0C sra, 0x0D srl, 0x0E/0x0F sll, 0x10 mult, 0x11 multu, 0x12 div, 0x13 divu, 0x14 mthi, 0x15 mtlo; all other codes SHALL give r=0, all flags 0, done after 1 cycle.
REQ-013 FSM states IDLE, RUN, DONE; IDLE/DONE accept start; single-cycle op (0x00-0x0F, 0x14, 0x15, unused) SHALL go to DONE; 0x10-0x13 SHALL go to RUN.
REQ-014 RUN SHALL last exactly WIDTH cycles (one radix-2 step per cycle), busy=1 throughout, then DONE.
REQ-015 DONE SHALL last one cycle with done=1, busy=0; without a new start it SHALL return to IDLE.
REQ-016 Latency: done SHALL rise 1 edge after start sampling for single-cycle ops, WIDTH+1 edges for mul/div; back-to-back start in DONE SHALL be accepted.
REQ-017 start while busy=1 SHALL be ignored, no state or output change.
REQ-018 r and flags SHALL update on the edge entering DONE and hold until the next completion.
REQ-019 Shift amount SHALL be a[$clog2(WIDTH)-1:0]; sll/srl/sra shift b; lui r = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-020 carry: addu carry-out; subu and sltu borrow (a<b unsigned); shifts last bit shifted out, 0 for amount 0; all other ops 0.
REQ-021 overflow: add/sub two's-complement signed overflow (operand-sign rule, not bit WIDTH); all other ops 0; add/sub SHALL still write r.
REQ-022 zero = (r==0), negative = r[WIDTH-1] for every op.
REQ-023 mult/multu: {hi,lo} = 2*WIDTH-bit signed/unsigned product.
REQ-024 div/divu: lo = quotient, hi = remainder; signed truncates toward zero, remainder sign follows dividend.
REQ-025 Divide by zero SHALL not hang: lo = all-ones, hi = a, normal latency.
REQ-026 Signed MIN / -1 SHALL give lo = MIN, hi = 0.
REQ-027 mthi: hi<=a; mtlo: lo<=a; r=a for both.
REQ-028 For mul/div, r SHALL equal new lo; hi/lo SHALL change only when entering DONE from mul/div/mthi/mtlo.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, r=0, all flags 0, hi=0, lo=0, iteration counter 0.
REQ-030 Reset during RUN SHALL abort the operation; no done pulse SHALL follow.

Structure
REQ-031 Package alu_pkg SHALL hold op code constants, FSM state enum and default WIDTH.
REQ-032 Iterative multiply/divide SHALL be sub-module alu_muldiv_iter (shift-add multiplier, restoring divider, shared counter); single-cycle ops stay in alu_mdu.

Verification (WIDTH=32)
REQ-033 add a=0x7FFFFFFF b=1 -> next cycle r=0x80000000, overflow=1, negative=1, carry=0, done=1.
REQ-034 multu a=b=0xFFFFFFFF -> busy 32 cycles, done at edge 33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 div a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=5 b=0 -> lo=0xFFFFFFFF, hi=5.
REQ-036 sra a=4 b=0x80000010 -> r=0xF8000001, carry=0; srl a=1 b=3 -> r=1, carry=1.
REQ-037 mult started, start pulsed with op=mthi at cycle 5 (ignored), rst_n low at cycle 10 -> no done, hi=lo=0, busy=0.
